// File: rtl/derotate_seq.sv
// derotate_seq: sequential right-rotator. One log-shifter stage is evaluated
// per cycle, so every word takes exactly STAGES cycles from accept to result,
// independent of the rotate amount.
module derotate_seq #(
  parameter int DATA_WIDTH = 8,
  localparam int STAGES    = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [STAGES-1:0]     i_amt,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  // Counter holds 0..STAGES so it never wraps while BUSY.
  localparam int KW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state_q;
  logic [DATA_WIDTH-1:0]         work_q;
  logic [STAGES-1:0]             amt_q;
  logic [KW-1:0]                 k_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic                          valid_q;
  logic                          ready_q;

  logic [STAGES-1:0][DATA_WIDTH-1:0] stage_rot;
  logic [DATA_WIDTH-1:0]             work_d;
  logic                              last_stage;

  // Fixed-distance rotate for each stage: rotate right by 2^s, width-exact.
  for (genvar s = 0; s < STAGES; s++) begin : g_rot
    localparam int SH = 1 << s;
    assign stage_rot[s] = {work_q[SH-1:0], work_q[DATA_WIDTH-1:SH]};
  end

  // Select the current stage's rotate when its amount bit is set.
  always_comb begin
    work_d = work_q;
    for (int s = 0; s < STAGES; s++) begin
      if (k_q == KW'(s) && amt_q[s]) work_d = stage_rot[s];
    end
  end

  assign last_stage = (k_q == KW'(STAGES - 1));

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            work_q  <= i_data;
            amt_q   <= i_amt;
            k_q     <= '0;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          k_q    <= k_q + KW'(1);
          if (last_stage) begin
            data_q  <= work_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Result held until the consumer takes it.
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
